sb_msg_decoder: RTL and testbench
=================================

Name: sb_msg_decoder

Overview:
Downstream consumer of the sideband receiver (SB_RX), in the 100 MHz domain. Pulls 64-bit sideband words from SB_RX using its msg_req/valid handshake, then checks the word's parity and opcode. Good words are split into fields and pushed into a small FIFO for the link-training / management logic; bad words are dropped and counted.

Parameters:
FIFO_DEPTH, 4, decoded-message FIFO entries (power of 2, >=2)
CNT_W, 8, width of saturating error counters
TIMEOUT_CYCLES, 1024, REQ-state cycles without rx_valid_i before timeout pulse (optional feature only)

Ports:
clk_100MHz  in  1  decoder clock
reset  in  1  asynchronous, active-high
enable_i  in  1  decoder enable; low forces IDLE
msg_req_o  out  1  request to SB_RX (drives its msg_req_i)
rx_valid_i  in  1  SB_RX valid_o
rx_data_i  in  64  SB_RX data_o
out_valid_o  out  1  FIFO non-empty
out_ready_i  in  1  consumer pop
out_opcode_o  out  5  head entry opcode (word[4:0])
out_srcid_o  out  3  head srcid (word[31:29])
out_msgcode_o  out  8  head msgcode (word[21:14])
out_dstid_o  out  3  head dstid (word[58:56])
out_msginfo_o  out  16  head msginfo (word[55:40])
out_subcode_o  out  8  head subcode (word[39:32])
par_err_cnt_o  out  CNT_W  saturating parity-error count
opc_err_cnt_o  out  CNT_W  saturating unknown-opcode count
timeout_o  out  1  one-cycle timeout pulse

Behaviour:
- Reset: state IDLE, msg_req_o=0, FIFO empty, out_valid_o=0, all out_*=0, both counters=0, timeout_o=0.
- FSM states:
  - IDLE: msg_req_o=0. Goes to REQ when enable_i=1.
  - REQ: msg_req_o=1 only while the FIFO has at least 1 free entry, counting the entry possibly in CHECK. A transfer happens on a clock edge where msg_req_o && rx_valid_i; rx_data_i is captured into a holding register and the FSM goes to CHECK.
  - CHECK: msg_req_o=0, so SB_RX sees msg_req drop for exactly one cycle after every transfer. Evaluate the held word and push or drop it. Next state is REQ, or IDLE if enable_i=0.
- Word check, in priority order:
  - Parity error if word[63] (dp) != 0, or word[62] (cp) != XOR of word[61:0]. Action: par_err_cnt++ and drop.
  - Otherwise, opcode error if word[4:0] != 5'h12 (message without data). Action: opc_err_cnt++ and drop.
  - Otherwise push the fields into the FIFO.
- Counters saturate at 2^CNT_W-1.
- Latency: transfer at edge N → push at edge N+1 → out_valid_o=1 after edge N+1.
- FIFO:
  - Show-ahead: out_* always show the head entry; out_* hold their last value while empty.
  - Pop happens on out_valid_o && out_ready_i.
  - A push and a pop in the same cycle are both allowed, including when full (the push is allowed because of the pop) and when empty (the pop is ignored).
  - Pointers wrap modulo FIFO_DEPTH.
- Full: msg_req_o stays 0 in REQ and no word is ever lost. It reasserts the cycle after a pop frees an entry.
- enable_i falling:
  - In REQ: go to IDLE the next cycle; no capture that edge.
  - In CHECK: finish the push/drop, then go to IDLE.
  - The FIFO is still drained by out_ready_i while in IDLE.
- rx_valid_i while msg_req_o=0 is ignored.
- Reset mid-transfer clears everything, including the holding register.

Optional Feature:
SB_MSG_TIMEOUT_EN:
- Defined: a counter runs while in REQ with msg_req_o=1 and clears on a transfer or on leaving REQ. When it reaches TIMEOUT_CYCLES, timeout_o pulses for 1 cycle and the counter restarts.
- Undefined: timeout_o is tied to 0 and there is no counter logic.

Test Plan:
- Good word: rx_data_i=64'h0500000A_20214012 with enable_i=1 → accepted. FIFO head: opcode=12, srcid=1, msgcode=85, dstid=5, msginfo=0000, subcode=0A. out_valid_o=1 two edges after msg_req_o&&rx_valid_i. Both counters stay 0.
- Parity error: 64'h4500000A_20214012 (cp flipped) → dropped, par_err_cnt_o=1, out_valid_o stays 0, msg_req_o=0 for 1 cycle then 1 again.
- Unknown opcode: 64'h4500000A_20214013 (parity valid) → dropped, opc_err_cnt_o=1, par_err_cnt_o unchanged.
- Backpressure: out_ready_i=0, stream 5 good words with FIFO_DEPTH=4 → 4 accepted, msg_req_o held 0 afterwards. Pulse out_ready_i once → msg_req_o returns to 1 the next cycle, 5th word accepted, FIFO order preserved.
- Enable/reset: drop enable_i in REQ → IDLE, msg_req_o=0 next cycle. Assert reset with 2 entries queued → out_valid_o=0 and counters=0 immediately (async).
- With SB_MSG_TIMEOUT_EN, TIMEOUT_CYCLES=16 and rx_valid_i=0 → timeout_o pulses 16 cycles after entering REQ, then every 16 cycles. Without the macro → timeout_o stays 0.

Source files
------------

// File: rtl/sb_msg_decoder.sv
// Sideband message decoder: pulls words from SB_RX, checks parity/opcode, queues good messages.
// Optional timeout pulse on an idle request: define SB_MSG_TIMEOUT_EN.
module sb_msg_decoder #(
    parameter int FIFO_DEPTH     = 4,
    parameter int CNT_W          = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clk_100MHz,
    input  logic             reset,
    input  logic             enable_i,
    output logic             msg_req_o,
    input  logic             rx_valid_i,
    input  logic [63:0]      rx_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [4:0]       out_opcode_o,
    output logic [2:0]       out_srcid_o,
    output logic [7:0]       out_msgcode_o,
    output logic [2:0]       out_dstid_o,
    output logic [15:0]      out_msginfo_o,
    output logic [7:0]       out_subcode_o,
    output logic [CNT_W-1:0] par_err_cnt_o,
    output logic [CNT_W-1:0] opc_err_cnt_o,
    output logic             timeout_o
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [4:0] OPC_MSG = 5'h12;

    generate
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0
            || CNT_W < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
            $error("sb_msg_decoder: illegal parameter value");
        end
    endgenerate

    typedef struct packed {
        logic [4:0]  opcode;
        logic [2:0]  srcid;
        logic [7:0]  msgcode;
        logic [2:0]  dstid;
        logic [15:0] msginfo;
        logic [7:0]  subcode;
    } msg_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_CHECK
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [63:0]      r_word;
    msg_t             r_mem [FIFO_DEPTH];
    msg_t             r_last;
    msg_t             w_head;
    msg_t             w_entry;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [CNT_W-1:0] r_par_cnt;
    logic [CNT_W-1:0] r_opc_cnt;

    logic w_full;
    logic w_empty;
    logic w_xfer;
    logic w_par_err;
    logic w_opc_err;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_count == DEPTH_C);
    assign w_empty = (r_count == '0);

    // Gated by enable so a falling enable never completes a handshake.
    assign msg_req_o = (r_state == S_REQ) && enable_i && !w_full;
    assign w_xfer    = msg_req_o && rx_valid_i;

    assign w_par_err = r_word[63] || (r_word[62] != (^r_word[61:0]));
    assign w_opc_err = !w_par_err && (r_word[4:0] != OPC_MSG);

    assign w_pop  = !w_empty && out_ready_i;
    assign w_push = (r_state == S_CHECK) && !w_par_err && !w_opc_err
                    && (!w_full || w_pop);

    assign w_entry.opcode  = r_word[4:0];
    assign w_entry.srcid   = r_word[31:29];
    assign w_entry.msgcode = r_word[21:14];
    assign w_entry.dstid   = r_word[58:56];
    assign w_entry.msginfo = r_word[55:40];
    assign w_entry.subcode = r_word[39:32];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (enable_i) w_state_nxt = S_REQ;
            end
            S_REQ: begin
                if (!enable_i)   w_state_nxt = S_IDLE;
                else if (w_xfer) w_state_nxt = S_CHECK;
            end
            S_CHECK: begin
                w_state_nxt = enable_i ? S_REQ : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_word  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_xfer) r_word <= rx_data_i;
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (w_push) r_mem[r_wr_ptr] <= w_entry;
    end

    // r_last keeps the most recently popped entry visible once empty.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_last   <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_last   <= r_mem[r_rd_ptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            r_par_cnt <= '0;
            r_opc_cnt <= '0;
        end else if (r_state == S_CHECK) begin
            if (w_par_err && r_par_cnt != '1) r_par_cnt <= r_par_cnt + 1'b1;
            if (w_opc_err && r_opc_cnt != '1) r_opc_cnt <= r_opc_cnt + 1'b1;
        end
    end

    assign w_head = w_empty ? r_last : r_mem[r_rd_ptr];

    assign out_valid_o   = !w_empty;
    assign out_opcode_o  = w_head.opcode;
    assign out_srcid_o   = w_head.srcid;
    assign out_msgcode_o = w_head.msgcode;
    assign out_dstid_o   = w_head.dstid;
    assign out_msginfo_o = w_head.msginfo;
    assign out_subcode_o = w_head.subcode;
    assign par_err_cnt_o = r_par_cnt;
    assign opc_err_cnt_o = r_opc_cnt;

`ifdef SB_MSG_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] r_to_cnt;
    logic          r_timeout;

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            if (r_state != S_REQ || w_xfer) begin
                r_to_cnt <= '0;
            end else if (msg_req_o) begin
                if (r_to_cnt == TO_LAST) begin
                    r_to_cnt  <= '0;
                    r_timeout <= 1'b1;
                end else begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                end
            end
        end
    end

    assign timeout_o = r_timeout;
`else
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_sb_msg_decoder.sv
// Scoreboard bench for sb_msg_decoder: directed sideband words, queued expectations.
module tb_sb_msg_decoder;

    typedef struct packed {
        logic [4:0]  opcode;
        logic [2:0]  srcid;
        logic [7:0]  msgcode;
        logic [2:0]  dstid;
        logic [15:0] msginfo;
        logic [7:0]  subcode;
    } exp_t;

    logic        clk_100MHz = 1'b0;
    logic        reset      = 1'b1;
    logic        enable_i   = 1'b0;
    logic        rx_valid_i = 1'b0;
    logic [63:0] rx_data_i  = '0;
    logic        out_ready_i = 1'b0;

    logic        msg_req_o;
    logic        out_valid_o;
    logic [4:0]  out_opcode_o;
    logic [2:0]  out_srcid_o;
    logic [7:0]  out_msgcode_o;
    logic [2:0]  out_dstid_o;
    logic [15:0] out_msginfo_o;
    logic [7:0]  out_subcode_o;
    logic [7:0]  par_err_cnt_o;
    logic [7:0]  opc_err_cnt_o;
    logic        timeout_o;

    sb_msg_decoder #(
        .FIFO_DEPTH     (4),
        .CNT_W          (8),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk_100MHz    (clk_100MHz),
        .reset         (reset),
        .enable_i      (enable_i),
        .msg_req_o     (msg_req_o),
        .rx_valid_i    (rx_valid_i),
        .rx_data_i     (rx_data_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .out_opcode_o  (out_opcode_o),
        .out_srcid_o   (out_srcid_o),
        .out_msgcode_o (out_msgcode_o),
        .out_dstid_o   (out_dstid_o),
        .out_msginfo_o (out_msginfo_o),
        .out_subcode_o (out_subcode_o),
        .par_err_cnt_o (par_err_cnt_o),
        .opc_err_cnt_o (opc_err_cnt_o),
        .timeout_o     (timeout_o)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    exp_t        q[$];
    exp_t        mon_e;
    int          n_chk  = 0;
    int          n_pass = 0;
    logic [63:0] gw [5];
    exp_t        ge [5];
    logic [42:0] w_out;

    localparam logic [63:0] PERR_W = 64'h4500000A_20214012;
    localparam logic [63:0] OERR_W = 64'h4500000A_20214013;

    assign w_out = {out_opcode_o, out_srcid_o, out_msgcode_o,
                    out_dstid_o, out_msginfo_o, out_subcode_o};

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(negedge clk_100MHz) begin
        if (!reset && out_valid_o && out_ready_i) begin
            if (q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_pop: got %0h expected no entry", w_out);
            end else begin
                mon_e = q.pop_front();
                chk("fifo_head", 64'(w_out), 64'(mon_e));
            end
        end
    end

    task automatic send(input logic [63:0] w);
        bit ok;
        ok = 1'b0;
        rx_data_i  = w;
        rx_valid_i = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_100MHz);
            if (msg_req_o) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_chk++;
            $display("FAIL send_timeout: msg_req_o=0 expected 1");
        end
        @(posedge clk_100MHz);
        #1;
        rx_valid_i = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk_100MHz);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k_first;
        int k_second;
        int seen;

        gw[0] = 64'h0500000A_20214012;
        gw[1] = 64'h07FFFFFF_E03FC012;
        gw[2] = 64'h0212345A_C00F0012;
        gw[3] = 64'h40000001_00000012;
        gw[4] = 64'h43A5A500_40204012;
        ge[0] = {5'h12, 3'd1, 8'h85, 3'd5, 16'h0000, 8'h0A};
        ge[1] = {5'h12, 3'd7, 8'hFF, 3'd7, 16'hFFFF, 8'hFF};
        ge[2] = {5'h12, 3'd6, 8'h3C, 3'd2, 16'h1234, 8'h5A};
        ge[3] = {5'h12, 3'd0, 8'h00, 3'd0, 16'h0000, 8'h01};
        ge[4] = {5'h12, 3'd2, 8'h81, 3'd3, 16'hA5A5, 8'h00};

        repeat (3) @(posedge clk_100MHz);
        #1;
        chk("rst_req", 64'(msg_req_o), 64'd0);
        chk("rst_valid", 64'(out_valid_o), 64'd0);
        chk("rst_fields", 64'(w_out), 64'd0);
        chk("rst_par", 64'(par_err_cnt_o), 64'd0);
        chk("rst_opc", 64'(opc_err_cnt_o), 64'd0);
        chk("rst_timeout", 64'(timeout_o), 64'd0);

        reset    = 1'b0;
        enable_i = 1'b1;
        tick();
        chk("req_after_enable", 64'(msg_req_o), 64'd1);

        q.push_back(ge[0]);
        send(gw[0]);
        chk("check_req_low", 64'(msg_req_o), 64'd0);
        chk("latency_not_yet", 64'(out_valid_o), 64'd0);
        tick();
        chk("latency_valid", 64'(out_valid_o), 64'd1);
        chk("req_back", 64'(msg_req_o), 64'd1);
        chk("good_par", 64'(par_err_cnt_o), 64'd0);
        chk("good_opc", 64'(opc_err_cnt_o), 64'd0);
        out_ready_i = 1'b1;
        tick();
        tick();
        out_ready_i = 1'b0;
        chk("empty_after_pop", 64'(out_valid_o), 64'd0);
        chk("hold_when_empty", 64'(w_out), 64'(ge[0]));

        send(PERR_W);
        chk("perr_req_drop", 64'(msg_req_o), 64'd0);
        tick();
        chk("perr_req_back", 64'(msg_req_o), 64'd1);
        chk("perr_cnt", 64'(par_err_cnt_o), 64'd1);
        chk("perr_opc", 64'(opc_err_cnt_o), 64'd0);
        chk("perr_dropped", 64'(out_valid_o), 64'd0);

        send(OERR_W);
        tick();
        chk("oerr_cnt", 64'(opc_err_cnt_o), 64'd1);
        chk("oerr_par", 64'(par_err_cnt_o), 64'd1);
        chk("oerr_dropped", 64'(out_valid_o), 64'd0);

        out_ready_i = 1'b1;
        for (int i = 1; i < 5; i++) begin
            q.push_back(ge[i]);
            send(gw[i]);
        end
        repeat (4) tick();
        out_ready_i = 1'b0;
        chk("stream_drained", 64'(q.size()), 64'd0);

        for (int i = 0; i < 4; i++) begin
            q.push_back(ge[i]);
            send(gw[i]);
        end
        tick();
        chk("full_req_low", 64'(msg_req_o), 64'd0);
        chk("full_valid", 64'(out_valid_o), 64'd1);
        rx_data_i  = gw[4];
        rx_valid_i = 1'b1;
        q.push_back(ge[4]);
        repeat (3) tick();
        chk("full_hold", 64'(msg_req_o), 64'd0);
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        chk("req_after_pop", 64'(msg_req_o), 64'd1);
        tick();
        rx_valid_i = 1'b0;
        chk("xfer_after_pop", 64'(msg_req_o), 64'd0);
        tick();
        chk("full_again", 64'(msg_req_o), 64'd0);
        out_ready_i = 1'b1;
        repeat (6) tick();
        out_ready_i = 1'b0;
        chk("bp_drained", 64'(q.size()), 64'd0);
        chk("bp_empty", 64'(out_valid_o), 64'd0);

        for (int i = 0; i < 260; i++) send(PERR_W);
        tick();
        chk("par_saturate", 64'(par_err_cnt_o), 64'd255);
        chk("opc_unchanged", 64'(opc_err_cnt_o), 64'd1);

`ifdef SB_MSG_TIMEOUT_EN
        enable_i = 1'b0;
        tick();
        tick();
        enable_i = 1'b1;
        @(posedge clk_100MHz);
        k_first  = 0;
        k_second = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (timeout_o) begin
                if (k_first == 0) k_first = k;
                else if (k_second == 0) k_second = k;
            end
        end
        chk("timeout_first", 64'(k_first), 64'd16);
        chk("timeout_second", 64'(k_second), 64'd32);
`else
        k_first  = 0;
        k_second = 0;
        seen = 0;
        repeat (40) begin
            @(negedge clk_100MHz);
            if (timeout_o) seen++;
        end
        chk("timeout_off", 64'(seen), 64'd0);
        tick();
`endif

        enable_i   = 1'b0;
        rx_data_i  = gw[0];
        rx_valid_i = 1'b1;
        #1;
        chk("disable_req_comb", 64'(msg_req_o), 64'd0);
        tick();
        chk("disable_idle", 64'(msg_req_o), 64'd0);
        repeat (2) tick();
        chk("disable_no_capture", 64'(out_valid_o), 64'd0);
        rx_valid_i = 1'b0;
        enable_i   = 1'b1;
        tick();

        q.push_back(ge[2]);
        send(gw[2]);
        enable_i = 1'b0;
        tick();
        chk("check_finishes", 64'(out_valid_o), 64'd1);
        chk("check_to_idle", 64'(msg_req_o), 64'd0);
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        chk("idle_drain", 64'(out_valid_o), 64'd0);
        chk("idle_drain_sb", 64'(q.size()), 64'd0);

        enable_i = 1'b1;
        tick();
        q.push_back(ge[1]);
        send(gw[1]);
        q.push_back(ge[3]);
        send(gw[3]);
        tick();
        chk("two_queued", 64'(out_valid_o), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_valid", 64'(out_valid_o), 64'd0);
        chk("arst_par", 64'(par_err_cnt_o), 64'd0);
        chk("arst_opc", 64'(opc_err_cnt_o), 64'd0);
        chk("arst_req", 64'(msg_req_o), 64'd0);
        chk("arst_fields", 64'(w_out), 64'd0);
        q.delete();
        tick();
        reset = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
